// File: rtl/sap1_arb_pkg.sv
// Shared types and default widths for the SAP-1 RAM arbiter.
package sap1_arb_pkg;

   localparam int ARB_ADDR_W   = 4;
   localparam int ARB_DATA_W   = 8;
   localparam int ARB_MAX_HOLD = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_LDR  = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/sap1_ram_arbiter_if.sv
// Requester, loader and RAM-side signals of the SAP-1 RAM arbiter.
interface sap1_ram_arbiter_if
   import sap1_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
);

   // Handshake: a requester raises req with we/addr/wdata and holds them
   // unchanged until it sees the one-cycle gnt pulse; req still high on the
   // cycle after gnt is a new request. Read data arrives with rvalid one
   // cycle after gnt and rdata then holds until the next read completes.
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              ldr_req;
   logic              ldr_we;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata;
   logic              ldr_lock;
   logic              ldr_gnt;
   logic              ldr_rvalid;
   logic [DATA_W-1:0] ldr_rdata;

   logic              ram_ce;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   owner_e            owner;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
      input  ram_rdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
      output ldr_gnt, ldr_rvalid, ldr_rdata,
      output ram_ce, ram_we, ram_addr, ram_wdata,
      output owner
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
      output ram_rdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
      input  ldr_gnt, ldr_rvalid, ldr_rdata,
      input  ram_ce, ram_we, ram_addr, ram_wdata,
      input  owner
   );

endinterface

// File: rtl/sap1_arb_fair_ctr.sv
// Saturating count of CPU wins taken while the loader waits; force_ldr_o
// tells the arbiter to hand the next decision to the loader.
module sap1_arb_fair_ctr #(
   parameter int MAX_HOLD = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic cpu_win_i,
   input  logic ldr_win_i,
   input  logic ldr_req_i,
   output logic force_ldr_o
);

   localparam int CW = $clog2(MAX_HOLD + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ldr_win_i || !ldr_req_i) begin
         cnt_d = '0;
      end else if (cpu_win_i && (cnt_q != CW'(MAX_HOLD))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign force_ldr_o = (cnt_q == CW'(MAX_HOLD));

endmodule

// File: rtl/sap1_ram_arbiter.sv
// SAP-1 16x8 RAM arbiter between the CPU sequencer and the loader port.
// Define SAP1_ARB_PERF_EN to add the cpu_stall_cnt output.
module sap1_ram_arbiter
   import sap1_arb_pkg::*;
#(
   parameter int ADDR_W   = ARB_ADDR_W,
   parameter int DATA_W   = ARB_DATA_W,
   parameter int MAX_HOLD = ARB_MAX_HOLD
) (
   input  logic               clk,
   input  logic               reset,
   sap1_ram_arbiter_if.slave  bus,
   output arb_state_e         arb_state_o
`ifdef SAP1_ARB_PERF_EN
   ,
   output logic [15:0]        cpu_stall_cnt
`endif
);

   arb_state_e        state_q, state_d;
   owner_e            own_q, own_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
   logic              cpu_elig, cpu_win, ldr_win, force_ldr;
   logic              live;

   // An access caught by reset is dropped, so strobes are masked while it is high.
   assign live     = ~reset;
   assign cpu_elig = bus.cpu_req & ~bus.ldr_lock;
   assign ldr_win  = (state_q == IDLE) & bus.ldr_req &
                     (bus.ldr_lock | ~cpu_elig | force_ldr);
   assign cpu_win  = (state_q == IDLE) & cpu_elig & ~ldr_win;

   sap1_arb_fair_ctr #(.MAX_HOLD(MAX_HOLD)) u_fair (
      .clk         (clk),
      .reset       (reset),
      .cpu_win_i   (cpu_win),
      .ldr_win_i   (ldr_win),
      .ldr_req_i   (bus.ldr_req),
      .force_ldr_o (force_ldr)
   );

   always_comb begin
      state_d        = state_q;
      own_d          = own_q;
      we_d           = we_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      cpu_rdata_d    = cpu_rdata_q;
      ldr_rdata_d    = ldr_rdata_q;
      bus.cpu_gnt    = 1'b0;
      bus.ldr_gnt    = 1'b0;
      bus.cpu_rvalid = 1'b0;
      bus.ldr_rvalid = 1'b0;
      bus.ram_ce     = 1'b0;
      bus.ram_we     = 1'b0;
      bus.ram_addr   = '0;
      bus.ram_wdata  = '0;
      case (state_q)
         IDLE: begin
            if (cpu_win) begin
               own_d   = OWN_CPU;
               we_d    = bus.cpu_we;
               addr_d  = bus.cpu_addr;
               wdata_d = bus.cpu_wdata;
               state_d = ISSUE;
            end else if (ldr_win) begin
               own_d   = OWN_LDR;
               we_d    = bus.ldr_we;
               addr_d  = bus.ldr_addr;
               wdata_d = bus.ldr_wdata;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            bus.ram_ce    = live;
            bus.ram_we    = we_q & live;
            bus.ram_addr  = live ? addr_q : '0;
            bus.ram_wdata = live ? wdata_q : '0;
            bus.cpu_gnt   = live & (own_q == OWN_CPU);
            bus.ldr_gnt   = live & (own_q == OWN_LDR);
            state_d       = we_q ? IDLE : RESP;
         end
         RESP: begin
            if (own_q == OWN_CPU) begin
               bus.cpu_rvalid = live;
               cpu_rdata_d    = bus.ram_rdata;
            end else begin
               bus.ldr_rvalid = live;
               ldr_rdata_d    = bus.ram_rdata;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         own_q       <= OWN_NONE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
      end
   end

   // Read data is forwarded in the rvalid cycle, then held from the register.
   assign bus.cpu_rdata = bus.cpu_rvalid ? bus.ram_rdata : cpu_rdata_q;
   assign bus.ldr_rdata = bus.ldr_rvalid ? bus.ram_rdata : ldr_rdata_q;
   assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_gnt;
   assign bus.owner     = (live && (state_q != IDLE)) ? own_q : OWN_NONE;
   assign arb_state_o   = state_q;

`ifdef SAP1_ARB_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (bus.cpu_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign cpu_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sap1_ram_arbiter.sv
// Bench for sap1_ram_arbiter: transaction-timeline model checked every cycle
// plus directed scenarios with literal expectations.
module tb_sap1_ram_arbiter;
   import sap1_arb_pkg::*;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int MH = 8;

   logic clk;
   logic reset;
   arb_state_e dbg_state;
`ifdef SAP1_ARB_PERF_EN
   logic [15:0] stall_cnt;
`endif

   sap1_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sap1_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .arb_state_o (dbg_state)
`ifdef SAP1_ARB_PERF_EN
      ,
      .cpu_stall_cnt (stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM macro: registered read, data one cycle after ram_ce
   logic [DW-1:0] ram_mem [16];
   always_ff @(posedge clk) begin
      if (bus.ram_ce) begin
         if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
         bus.ram_rdata <= ram_mem[bus.ram_addr];
      end
   end

   // ---------------- scoreboard / model state ----------------
   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int next_dec = 0;
   int fair     = 0;
   int stall_m  = 0;
   int cnt_cg   = 0;
   int cnt_stall = 0;
   logic obs_cg = 1'b0;
   logic obs_lg = 1'b0;
   logic [DW-1:0] mem_m [16];
   logic [DW-1:0] held_c = '0;
   logic [DW-1:0] held_l = '0;
   // per-cycle expectation slots, indexed by cycle modulo 4
   logic          s_gc [4];
   logic          s_gl [4];
   logic          s_ce [4];
   logic          s_we [4];
   logic [AW-1:0] s_ad [4];
   logic [DW-1:0] s_wd [4];
   logic [DW-1:0] s_rd [4];
   logic [1:0]    s_own [4];
   logic          s_rc [4];
   logic          s_rl [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_slot(input int s);
      s_gc[s] = 1'b0; s_gl[s] = 1'b0; s_ce[s] = 1'b0; s_we[s] = 1'b0;
      s_ad[s] = '0;   s_wd[s] = '0;   s_rd[s] = '0;   s_own[s] = 2'd0;
      s_rc[s] = 1'b0; s_rl[s] = 1'b0;
   endtask

   task automatic model_step();
      int i, j, k;
      bit ec, el, lw, cw, twe;
      logic [AW-1:0] ta;
      logic [DW-1:0] td, e_rc, e_rl;
      logic e_stall;
      i = cyc % 4; j = (cyc + 1) % 4; k = (cyc + 2) % 4;
      obs_cg = bus.cpu_gnt;
      obs_lg = bus.ldr_gnt;
      if (bus.cpu_gnt === 1'b1) cnt_cg++;
      if (bus.cpu_stall === 1'b1) cnt_stall++;
      if (reset) begin
         chk("rst_quiet", 32'({bus.cpu_gnt, bus.ldr_gnt, bus.cpu_rvalid, bus.ldr_rvalid, bus.ram_ce,
                               bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.owner}), 32'd0);
         chk("rst_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req));
         chk("rst_rdata", 32'({bus.cpu_rdata, bus.ldr_rdata}), 32'({held_c, held_l}));
`ifdef SAP1_ARB_PERF_EN
         chk("rst_stall_cnt", 32'(stall_cnt), 32'(stall_m));
`endif
         for (int s = 0; s < 4; s++) clear_slot(s);
         held_c = '0; held_l = '0; fair = 0; stall_m = 0;
         next_dec = cyc + 1;
      end else begin
         e_rc    = s_rc[i] ? s_rd[i] : held_c;
         e_rl    = s_rl[i] ? s_rd[i] : held_l;
         e_stall = bus.cpu_req & ~s_gc[i];
         chk("ram_bus", 32'({bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_wdata}),
             32'({s_ce[i], s_we[i], s_ad[i], s_wd[i]}));
         chk("gnt", 32'({bus.cpu_gnt, bus.ldr_gnt}), 32'({s_gc[i], s_gl[i]}));
         chk("rvalid", 32'({bus.cpu_rvalid, bus.ldr_rvalid}), 32'({s_rc[i], s_rl[i]}));
         chk("owner", 32'(bus.owner), 32'(s_own[i]));
         chk("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
         chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rc));
         chk("ldr_rdata", 32'(bus.ldr_rdata), 32'(e_rl));
`ifdef SAP1_ARB_PERF_EN
         chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
         if (e_stall && stall_m < 16'hFFFF) stall_m++;
`endif
         held_c = e_rc; held_l = e_rl;
         clear_slot(i);
         if (cyc == next_dec) begin
            ec = bus.cpu_req && !bus.ldr_lock;
            el = bus.ldr_req;
            lw = el && (bus.ldr_lock || !ec || fair == MH);
            cw = ec && !lw;
            if (lw || cw) begin
               twe = lw ? bus.ldr_we    : bus.cpu_we;
               ta  = lw ? bus.ldr_addr  : bus.cpu_addr;
               td  = lw ? bus.ldr_wdata : bus.cpu_wdata;
               s_gc[j] = cw; s_gl[j] = lw; s_ce[j] = 1'b1; s_we[j] = twe;
               s_ad[j] = ta; s_wd[j] = td; s_own[j] = cw ? 2'd1 : 2'd2;
               if (twe) begin
                  mem_m[ta] = td;
                  next_dec  = cyc + 2;
               end else begin
                  s_own[k] = cw ? 2'd1 : 2'd2;
                  s_rc[k] = cw; s_rl[k] = lw; s_rd[k] = mem_m[ta];
                  next_dec = cyc + 3;
               end
            end else begin
               next_dec = cyc + 1;
            end
            if (lw || !el) fair = 0;
            else if (cw && fair < MH) fair++;
         end else if (!bus.ldr_req) begin
            fair = 0;
         end
      end
      cyc++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic neg();
      @(negedge clk);
      model_step();
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
   endtask

   task automatic do_access(input bit ldr, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output logic [DW-1:0] rd);
      bit ok;
      ok = 1'b0;
      if (ldr) begin bus.ldr_req = 1'b1; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d; end
      else     begin bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; end
      for (int t = 0; t < 60; t++) begin
         neg();
         if ((ldr ? bus.ldr_gnt : bus.cpu_gnt) === 1'b1) begin ok = 1'b1; break; end
         pos();
      end
      chk("access_gnt_seen", 32'(ok), 32'd1);
      pos();
      if (ldr) bus.ldr_req = 1'b0; else bus.cpu_req = 1'b0;
      rd = '0;
      if (ok && !we) begin
         neg();
         rd = ldr ? bus.ldr_rdata : bus.cpu_rdata;
         chk("access_rvalid", 32'(ldr ? bus.ldr_rvalid : bus.cpu_rvalid), 32'd1);
         pos();
      end
   endtask

   // ---------------- main sequence ----------------
   logic [DW-1:0] rd;
   int ncg, got, c0, s0, y0;

   initial begin
      reset = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
      bus.ldr_lock = 1'b0;
      repeat (3) begin neg(); pos(); end
      chk("reset_state_idle", 32'(dbg_state), 32'(IDLE));
      chk("reset_rdata_zero", 32'({bus.cpu_rdata, bus.ldr_rdata, bus.owner}), 32'd0);
      reset = 1'b0;

      // preload every RAM word through the loader port
      for (int a = 0; a < 16; a++) do_access(1'b1, 1'b1, AW'(a), DW'($urandom_range(0, 255)), rd);
      do_access(1'b1, 1'b1, 4'hA, 8'h2F, rd);

      // CPU read of 0xA: gnt at +1, rvalid at +2
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'hA;
      neg();
      chk("rd_a_stall_req", 32'({bus.cpu_stall, bus.ram_ce}), 32'b10);
      pos(); neg();
      chk("rd_a_issue", 32'({bus.cpu_gnt, bus.ram_ce, bus.ram_we, bus.ram_addr, bus.cpu_stall}),
          32'({1'b1, 1'b1, 1'b0, 4'hA, 1'b0}));
      pos(); bus.cpu_req = 1'b0; neg();
      chk("rd_a_resp", 32'({bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_stall}), 32'({1'b1, 8'h2F, 1'b0}));
      pos();

      // loader write then CPU read-back
      do_access(1'b1, 1'b1, 4'h3, 8'h55, rd);
      do_access(1'b0, 1'b0, 4'h3, 8'h00, rd);
      chk("ldr_wr_cpu_rd", 32'(rd), 32'h55);

      // simultaneous requests with fairness at zero
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'h3;
      bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 4'h5; bus.ldr_wdata = 8'h66;
      neg(); pos(); neg();
      chk("simul_cpu_first", 32'({bus.cpu_gnt, bus.ldr_gnt}), 32'b10);
      pos(); bus.cpu_req = 1'b0; neg(); pos(); neg(); pos(); neg();
      chk("simul_ldr_next", 32'({bus.cpu_gnt, bus.ldr_gnt}), 32'b01);
      pos(); bus.ldr_req = 1'b0;
      neg(); pos();

      // continuous CPU writes while the loader waits
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 4'h8; bus.cpu_wdata = 8'h00;
      bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 4'h7; bus.ldr_wdata = 8'h77;
      ncg = 0; got = 0;
      for (int t = 0; t < 100; t++) begin
         neg();
         if (bus.ldr_gnt === 1'b1) begin got = 1; break; end
         if (bus.cpu_gnt === 1'b1) ncg++;
         pos();
         if (obs_cg) bus.cpu_wdata = bus.cpu_wdata + 8'd1;
      end
      chk("fair_cpu_burst", 32'(ncg), 32'd8);
      chk("fair_ldr_won", 32'(got), 32'd1);
      pos(); bus.ldr_req = 1'b0; neg(); pos(); neg();
      chk("fair_cpu_resume", 32'(bus.cpu_gnt), 32'd1);
      pos(); bus.cpu_req = 1'b0; neg(); pos();

      // programming lock holds the CPU off
      bus.ldr_lock = 1'b1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'h3;
      c0 = cnt_cg; s0 = cnt_stall; y0 = cyc;
      do_access(1'b1, 1'b1, 4'h9, 8'h99, rd);
      do_access(1'b1, 1'b0, 4'h9, 8'h00, rd);
      chk("lock_ldr_read", 32'(rd), 32'h99);
      chk("lock_no_cpu_gnt", 32'(cnt_cg - c0), 32'd0);
      chk("lock_stall_held", 32'(cnt_stall - s0), 32'(cyc - y0));
      bus.ldr_lock = 1'b0;
      neg(); pos(); neg();
      chk("unlock_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
      pos(); bus.cpu_req = 1'b0; neg();
      chk("unlock_cpu_rdata", 32'({bus.cpu_rvalid, bus.cpu_rdata}), 32'({1'b1, 8'h55}));
      pos();

      // randomized traffic checked by the model
      for (int t = 0; t < 1500; t++) begin
         if (obs_cg || !bus.cpu_req) begin
            bus.cpu_req   = ($urandom_range(0, 99) < 60);
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = AW'($urandom_range(0, 15));
            bus.cpu_wdata = DW'($urandom_range(0, 255));
         end
         if (obs_lg || !bus.ldr_req) begin
            bus.ldr_req   = ($urandom_range(0, 99) < 40);
            bus.ldr_we    = 1'($urandom_range(0, 1));
            bus.ldr_addr  = AW'($urandom_range(0, 15));
            bus.ldr_wdata = DW'($urandom_range(0, 255));
         end
         if ($urandom_range(0, 39) == 0) bus.ldr_lock = ~bus.ldr_lock;
         neg(); pos();
      end
      bus.ldr_lock = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (obs_cg) bus.cpu_req = 1'b0;
         if (obs_lg) bus.ldr_req = 1'b0;
         neg(); pos();
      end
      chk("drain_done", 32'({bus.cpu_req, bus.ldr_req}), 32'd0);
      bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
      repeat (3) begin neg(); pos(); end

      // reset during RESP of a loader read
      bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 4'h3;
      neg(); pos(); neg();
      chk("rst_rd_gnt", 32'(bus.ldr_gnt), 32'd1);
      pos(); bus.ldr_req = 1'b0; reset = 1'b1;
      neg();
      chk("rst_no_ldr_rvalid", 32'(bus.ldr_rvalid), 32'd0);
      pos(); reset = 1'b0;
      neg();
      chk("rst_after_outputs", 32'({bus.cpu_gnt, bus.ldr_gnt, bus.cpu_rvalid, bus.ldr_rvalid, bus.cpu_stall,
                                    bus.ram_ce, bus.owner, bus.cpu_rdata, bus.ldr_rdata}), 32'd0);
`ifdef SAP1_ARB_PERF_EN
      chk("rst_after_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      pos();
      repeat (2) begin neg(); pos(); end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sap1_ram_arbiter.md
Name: sap1_ram_arbiter

Overview:
Arbitrates the SAP-1 16x8 program/data RAM between two requesters:
- the CPU side, i.e. MAR/RAM accesses issued by the sequencer during fetch/execute;
- an external loader/debug port that writes programs and reads back memory.

It sits between both requesters and the RAM macro. It serialises single-word accesses, returns read data, and stalls the sequencer's T-state advance while the CPU waits.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, RAM data width
MAX_HOLD, 8, consecutive CPU grants allowed while loader waits before loader is forced a grant

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held with payload until cpu_gnt
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  one-cycle pulse: CPU access issued to RAM
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
cpu_rdata  out  DATA_W  CPU read data, held until next CPU read
cpu_stall  out  1  sequencer hold: cpu_req high and CPU not granted this cycle
ldr_req  in  1  loader request, same rules as cpu_req
ldr_we  in  1  loader write enable
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_lock  in  1  programming mode: loader exclusive, CPU requests ignored
ldr_gnt  out  1  loader grant pulse
ldr_rvalid  out  1  loader read-data pulse
ldr_rdata  out  DATA_W  loader read data, held
ram_ce  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_ce
owner  out  2  current owner: 0 none, 1 CPU, 2 loader

Behaviour:
- Reset: state IDLE; every output 0, including rdata registers, owner and the fairness counter.
- Reset mid-access drops the access: no gnt and no rvalid is produced for it.
- FSM states IDLE, ISSUE, RESP.
- IDLE: if any eligible request, pick a winner and register owner/we/addr/wdata; go to ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - Drive ram_ce=1, ram_we, ram_addr and ram_wdata from the registers.
  - Pulse the winner's gnt.
  - Write: go to IDLE. Read: go to RESP.
- RESP: capture ram_rdata into the winner's rdata, pulse its rvalid, go to IDLE.
- ram_* outputs are 0 outside ISSUE.
- Latency from request in IDLE:
  - gnt at cycle +1;
  - rvalid at cycle +2;
  - back-to-back throughput: write every 2 cycles, read every 3.
- Requester rule: req and payload stay stable until the gnt pulse. If req is still high the cycle after gnt, it is a new request.
- Priority:
  - ldr_lock=1: only the loader is eligible.
  - Otherwise CPU wins, unless fair_cnt==MAX_HOLD and ldr_req=1, in which case the loader wins.
- fair_cnt:
  - increments (saturating at MAX_HOLD) on each CPU win while ldr_req=1;
  - clears on a loader win or when ldr_req=0.
- ldr_lock rising during a CPU access: the in-flight access completes normally; lock takes effect at the next IDLE decision.
- owner = registered winner during ISSUE/RESP, 0 in IDLE.
- cpu_stall is combinational: cpu_req & ~cpu_gnt. It is high in IDLE with a pending request, and during any loader ownership.

Optional Feature:
SAP1_ARB_PERF_EN:
- Defined: adds output cpu_stall_cnt [15:0].
  - Increments every cycle cpu_stall=1 and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package sap1_arb_pkg holds:
  - ADDR_W/DATA_W defaults;
  - owner_e (OWN_NONE=0, OWN_CPU=1, OWN_LDR=2);
  - arb_state_e (IDLE, ISSUE, RESP).
- One sub-module, sap1_arb_fair_ctr: saturating fairness counter.
  - Inputs: cpu_win, ldr_win, ldr_req.
  - Output: force_ldr.

Test Plan:
- CPU read addr 4'hA with RAM[A]=8'h2F, loader idle:
  - cpu_gnt at +1 with ram_ce=1, ram_addr=A, ram_we=0;
  - cpu_rvalid at +2 with cpu_rdata=8'h2F;
  - cpu_stall=1 only in the request cycle.
- Loader write addr 3 data 8'h55, then CPU read addr 3:
  - ldr_gnt pulse, then cpu_rdata=8'h55.
- Simultaneous cpu_req/ldr_req in IDLE, fair_cnt=0: CPU granted first, loader granted on the next IDLE decision.
- CPU requests continuously with ldr_req held, MAX_HOLD=8: exactly 8 cpu_gnt pulses, then one ldr_gnt, then fair_cnt=0 and CPU resumes.
- ldr_lock=1 while cpu_req=1:
  - cpu_gnt never pulses and cpu_stall stays 1;
  - loader accesses proceed;
  - releasing lock grants CPU within 1 cycle of IDLE.
- reset asserted in RESP of a loader read:
  - next cycle all outputs 0, no ldr_rvalid;
  - with SAP1_ARB_PERF_EN, cpu_stall_cnt=0.
